// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor, one full-subtractor cell, LSB first
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o
);

    // One extra bit so the counter cannot wrap before reaching WIDTH-1.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             d_bit;
    logic             br_next;
    logic             accept;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
        br_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    end

    // Next-state and output logic; a new request is taken in IDLE or DONE.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sd_d    = sd_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_o  = 1'b0;
        valid_o = 1'b0;
        accept  = start_i && ((state_q == IDLE) || (state_q == DONE));

        case (state_q)
            IDLE: begin
            end
            RUN: begin
                busy_o = 1'b1;
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                sd_d   = {d_bit, sd_q[WIDTH-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d  = {d_bit, sd_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            sa_d    = a_i;
            sb_d    = b_i;
            br_d    = bin_i;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign diff_o = diff_q;
    assign bout_o = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // WIDTH=4 instance for directed cases
    logic       rst4 = 1'b1, start4 = 1'b0, bin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, valid4, bout4;
    logic [3:0] diff4;

    // WIDTH=8 instance for the random sweep
    logic       rst8 = 1'b1, start8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, valid8, bout8;
    logic [7:0] diff8;

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst4), .start_i(start4), .a_i(a4), .b_i(b4), .bin_i(bin4),
        .busy_o(busy4), .valid_o(valid4), .diff_o(diff4), .bout_o(bout4)
    );

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst8), .start_i(start8), .a_i(a8), .b_i(b8), .bin_i(bin8),
        .busy_o(busy8), .valid_o(valid8), .diff_o(diff8), .bout_o(bout8)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural model: result from plain arithmetic, timing as "busy for
    // WIDTH cycles after an accept, then one valid cycle".
    int         m4_rem = 0, m8_rem = 0, m8_done = 0;
    logic       m4_valid = 0, m4_bout = 0, m4_pb = 0;
    logic [3:0] m4_diff = '0, m4_pd = '0;
    logic       m8_valid = 0, m8_bout = 0, m8_pb = 0;
    logic [7:0] m8_diff = '0, m8_pd = '0;

    always @(posedge clk) begin
        if (rst4) begin
            m4_rem = 0; m4_valid = 0; m4_diff = '0; m4_bout = 0;
        end else if (m4_rem == 0) begin
            m4_valid = 0;
            if (start4) begin
                {m4_pb, m4_pd} = {1'b0, a4} - {1'b0, b4} - {4'd0, bin4};
                m4_rem = 4;
            end
        end else begin
            m4_rem--;
            if (m4_rem == 0) begin
                m4_valid = 1; m4_diff = m4_pd; m4_bout = m4_pb;
            end
        end
    end

    always @(posedge clk) begin
        if (rst8) begin
            m8_rem = 0; m8_valid = 0; m8_diff = '0; m8_bout = 0;
        end else if (m8_rem == 0) begin
            m8_valid = 0;
            if (start8) begin
                {m8_pb, m8_pd} = {1'b0, a8} - {1'b0, b8} - {8'd0, bin8};
                m8_rem = 8;
            end
        end else begin
            m8_rem--;
            if (m8_rem == 0) begin
                m8_valid = 1; m8_diff = m8_pd; m8_bout = m8_pb; m8_done++;
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy4",  busy4,  m4_rem != 0);
            chk("valid4", valid4, m4_valid);
            chk("diff4",  diff4,  m4_diff);
            chk("bout4",  bout4,  m4_bout);
            chk("busy8",  busy8,  m8_rem != 0);
            chk("valid8", valid8, m8_valid);
            chk("diff8",  diff8,  m8_diff);
            chk("bout8",  bout8,  m8_bout);
        end
    end

    // Wait for valid4, counting cycles since the accept; bounded.
    task automatic wait_valid4(inout int k);
        while (!valid4 && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                       input int ed, input int eb, input string nm);
        int k;
        @(negedge clk);
        a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
        k = 1;
        wait_valid4(k);
        chk({nm, "_lat"},   k,       5);
        chk({nm, "_diff"},  diff4,   ed);
        chk({nm, "_bout"},  bout4,   eb);
        chk({nm, "_model"}, m4_diff, ed);
    endtask

    initial begin
        int k;
        int cyc;

        repeat (3) @(negedge clk);
        chk("rst_busy",  busy4,  0);
        chk("rst_valid", valid4, 0);
        chk("rst_diff",  diff4,  0);
        chk("rst_bout",  bout4,  0);
        chk("rst_diff8", diff8,  0);
        chk_en = 1'b1;
        rst4 = 1'b0;
        rst8 = 1'b0;

        op4(4'd9,  4'd3,  1'b0, 6,  0, "basic");
        op4(4'd3,  4'd9,  1'b0, 10, 1, "under");
        op4(4'd0,  4'd0,  1'b1, 15, 1, "binonly");
        op4(4'd15, 4'd15, 1'b0, 0,  0, "equal");

        // Back-to-back with start held high
        @(negedge clk);
        a4 = 4'd12; b4 = 4'd5; bin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd12;
        k = 1;
        wait_valid4(k);
        chk("b2b1_lat",  k,     5);
        chk("b2b1_diff", diff4, 7);
        chk("b2b1_bout", bout4, 0);
        @(negedge clk);
        k = 1;
        wait_valid4(k);
        start4 = 1'b0;
        chk("b2b2_gap",  k,     5);
        chk("b2b2_diff", diff4, 9);
        chk("b2b2_bout", bout4, 1);
        repeat (3) @(negedge clk);

        // Start during RUN is ignored
        @(negedge clk);
        a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        k = 3;
        wait_valid4(k);
        chk("ign_lat",  k,     5);
        chk("ign_diff", diff4, 6);
        chk("ign_bout", bout4, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("ign_novalid", valid4, 0);
        end

        // Reset on the third RUN cycle
        @(negedge clk);
        a4 = 4'd8; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        chk("mrst_busy", busy4, 0);
        chk("mrst_diff", diff4, 0);
        chk("mrst_bout", bout4, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("mrst_novalid", valid4, 0);
        end
        op4(4'd8, 4'd1, 1'b0, 7, 0, "fresh");

        // WIDTH=8 random sweep, occasional resets, random start gaps
        cyc = 0;
        while (m8_done < 1000 && cyc < 30000) begin
            @(negedge clk);
            start8 = 1'($urandom_range(0, 1));
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            bin8   = 1'($urandom_range(0, 1));
            rst8   = ($urandom_range(0, 299) == 0);
            cyc++;
        end
        @(negedge clk);
        start8 = 1'b0;
        rst8 = 1'b0;
        chk("sweep_done", m8_done >= 1000, 1);
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor: computes diff = a − b − bin over WIDTH clock cycles, LSB first, with one full-subtractor cell and a registered borrow. It is the subtracting counterpart of the team's ripple-carry adder. It trades the adder's combinational carry chain for one bit of work per cycle, behind a start/busy/valid handshake. It sits in the datapath wherever area matters more than latency.

## Interface
- WIDTH, default 4, operand/result width in bits (≥ 2)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- start  input  1  request; accepted only when busy = 0
- a  input  WIDTH  minuend; sampled on the accepting edge only
- b  input  WIDTH  subtrahend; sampled on the accepting edge only
- bin  input  1  borrow-in; sampled on the accepting edge only
- busy  output  1  high while a subtraction is in progress
- valid  output  1  one-cycle pulse; diff/bout are new this cycle
- diff  output  WIDTH  result a − b − bin mod 2^WIDTH
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned)

## Operation
- States:
  - IDLE: busy=0. Start → RUN.
  - RUN: busy=1, WIDTH cycles.
  - DONE: busy=0, valid=1, exactly one cycle. Start accepted here (back-to-back), else → IDLE.
- Accept (IDLE or DONE with start=1):
  - Load shift registers sa←a, sb←b.
  - Load borrow register br←bin.
  - Bit counter cnt←0. State → RUN.
- Each RUN cycle, on LSB sa[0], sb[0]:
  - d = sa[0]^sb[0]^br
  - br ← (~sa[0] & sb[0]) | (~(sa[0]^sb[0]) & br)
  - Shift d into the MSB of the result shift register sd. Shift sa, sb right by one.
  - cnt ← cnt+1.
- Last RUN cycle (cnt = WIDTH−1):
  - diff ← final sd contents; bout ← final br.
  - State → DONE.
- diff/bout hold their value from the last completion until the next completion. They do not change during RUN.
- start while busy=1 is ignored. Inputs are not re-sampled and the operation is not restarted.
- cnt width is clog2(WIDTH)+1. It is compared against WIDTH−1 and must not wrap early.

## Timing
- Reset values: state=IDLE, busy=0, valid=0, diff=0, bout=0. Internal sa, sb, sd, br, cnt are all 0.
- rst has priority over all other activity. Asserting rst in any state (including mid-RUN) aborts the operation on that edge:
  - No valid pulse.
  - diff/bout return to 0.
- Latency, with start accepted on edge E0:
  - busy=1 for cycles E0+1 .. E0+WIDTH.
  - valid=1 with the new diff/bout in cycle E0+WIDTH+1.
  - Total: WIDTH+1 cycles from accept to valid.
- Throughput: one result per WIDTH+1 cycles with start held high continuously. Start in the DONE cycle re-enters RUN on the next edge, so busy and valid are never both 1.
- a, b, bin may change freely after the accepting edge.

## Test plan
- Basic subtraction, WIDTH=4: a=9, b=3, bin=0, one-cycle start → busy high 4 cycles, then valid pulse with diff=6, bout=0.
- Underflow: a=3, b=9, bin=0 → diff=10, bout=1.
  - a=0, b=0, bin=1 → diff=15, bout=1.
  - a=15, b=15, bin=0 → diff=0, bout=0.
- Back-to-back with start held high:
  - First operands a=12, b=5, then a=5, b=12, changed right after the first accept.
  - Valid pulses are exactly 5 cycles apart: diff=7/bout=0, then diff=9/bout=1.
- Ignored start: start pulsed with a=1, b=1 during the second RUN cycle of a=9−3 → that result is unaffected (6, bout 0). No extra valid follows.
- Reset mid-operation: rst asserted on the third RUN cycle of a=8, b=1:
  - Next cycle: busy=0, diff=0, bout=0.
  - No valid within the following 10 cycles.
  - A fresh start then completes normally.
- Width sweep: WIDTH=8, random a/b/bin, 1000 operations → diff and bout match (a − b − bin) mod 256 and the borrow model every time. Latency is 9 cycles.
